// File: rtl/alu_exec_pkg.sv
// Shared op codes, FSM states and helpers for the execute-stage ALU.
package alu_exec_pkg;
  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 4'b0000,
    OP_XOR = 4'b0001,
    OP_ADD = 4'b0010,
    OP_OR  = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic {IDLE, SHIFT} exec_state_e;

  function automatic logic is_shift(logic [OP_W-1:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction
endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter; last flags the final step, nxt is the value that step produces.
module alu_serial_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               load,
  input  logic [WIDTH-1:0]   value,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left,
  input  logic               arith,
  output logic               last,
  output logic [WIDTH-1:0]   nxt
);
  logic [WIDTH-1:0]   val;
  logic [SHAMT_W-1:0] cnt;
  logic               lft, ari;

  // Repeated 1-bit arithmetic right shifts keep replicating the original sign bit.
  always_comb begin
    nxt  = lft ? {val[WIDTH-2:0], 1'b0} : {ari & val[WIDTH-1], val[WIDTH-1:1]};
    last = (cnt == SHAMT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val <= '0;
      cnt <= '0;
      lft <= 1'b0;
      ari <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      val <= value;
      cnt <= shamt;
      lft <= left;
      ari <= arith;
    end else if (cnt != '0) begin
      val <= nxt;
      cnt <= cnt - SHAMT_W'(1);
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare, serial shifts, registered result with handshake.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  operation,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  exec_state_e        state_q, state_d;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_val, sh_nxt;
  logic               accept, go_shift, sh_last;

  assign shamt    = in_b[SHAMT_W-1:0];
  assign in_ready = reset && !flush && (state_q == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign go_shift = accept && is_shift(operation) && (shamt != '0);

  // Shift ops land here only with a zero shift amount, so they pass A through.
  always_comb begin
    alu_val = '0;
    case (operation)
      OP_AND:                 alu_val = in_a & in_b;
      OP_XOR:                 alu_val = in_a ^ in_b;
      OP_ADD:                 alu_val = in_a + in_b;
      OP_OR:                  alu_val = in_a | in_b;
      OP_SUB:                 alu_val = in_a - in_b;
      OP_SRL, OP_SLL, OP_SRA: alu_val = in_a;
      OP_EQ:                  alu_val = WIDTH'(in_a == in_b);
      OP_SLT:                 alu_val = WIDTH'($signed(in_a) < $signed(in_b));
      default:                alu_val = '0;
    endcase
  end

  alu_serial_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .load  (go_shift),
    .value (in_a),
    .shamt (shamt),
    .left  (operation == OP_SLL),
    .arith (operation == OP_SRA),
    .last  (sh_last),
    .nxt   (sh_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (go_shift) state_d = SHIFT;
        SHIFT:   if (sh_last)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (state_q == SHIFT && sh_last) begin
      out_valid <= 1'b1;
      result    <= sh_nxt;
      zero      <= (sh_nxt == '0);
    end else if (accept && !go_shift) begin
      out_valid <= 1'b1;
      result    <= alu_val;
      zero      <= (alu_val == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
